sub_shift_rows: RTL

- Iterative AES SubBytes + ShiftRows stage that sits directly upstream of mixColumns in the CPU core's AES datapath.
- Accepts a 128-bit state, applies the S-box and the row rotation one output column per cycle using four shared S-box instances, and presents the result on a valid/ready interface.
- The output word format matches the mixColumns input exactly, so the output connects to it unmodified.

---
 rtl/sub_shift_rows.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows: one output column per cycle through four
// shared S-boxes, with a valid/ready handshake on both sides.
module sub_shift_rows #(
  parameter int N = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:0] state_matrix_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:0] state_matrix_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [N:0] in_reg_q, in_reg_d;
  logic [N:0] out_reg_q, out_reg_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;

  logic [7:0]  in_byte_s [4][4];
  logic [7:0]  sbox_in_s [4];
  logic [7:0]  sbox_out_s [4];
  logic [31:0] col_word_s;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128); zero maps to zero naturally.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    logic [7:0] cst;
    logic [7:0] s;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    cst = 8'h63;
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
             inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ cst[i];
    end
    return s;
  endfunction

  // Row r of output column col_idx comes from input column (col_idx + r) mod 4.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        in_byte_s[r][c] = in_reg_q[N - 8 * (4 * c + r) -: 8];
      end
    end
    for (int r = 0; r < 4; r++) begin
      sbox_in_s[r]  = in_byte_s[r][col_idx_q + 2'(r)];
      sbox_out_s[r] = sbox(sbox_in_s[r]);
    end
    col_word_s = {sbox_out_s[0], sbox_out_s[1], sbox_out_s[2], sbox_out_s[3]};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    in_reg_d    = in_reg_q;
    out_reg_d   = out_reg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_reg_d   = state_matrix_in;
          col_idx_d  = 2'd0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      BUSY: begin
        case (col_idx_q)
          2'd0:    out_reg_d[N -: 32]      = col_word_s;
          2'd1:    out_reg_d[N - 32 -: 32] = col_word_s;
          2'd2:    out_reg_d[N - 64 -: 32] = col_word_s;
          2'd3:    out_reg_d[N - 96 -: 32] = col_word_s;
          default: out_reg_d = out_reg_q;
        endcase
        if (col_idx_q == 2'd3) begin
          col_idx_d   = 2'd0;
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        col_idx_d   = 2'd0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_idx_q   <= 2'd0;
      in_reg_q    <= '0;
      out_reg_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      in_reg_q    <= in_reg_d;
      out_reg_q   <= out_reg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign busy             = busy_q;
  assign state_matrix_out = out_reg_q;

endmodule
